// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT sequencing controller.
// The FILT state is only present when FFT_FILTER_EN is defined.
package fft_pkg;

  localparam int unsigned SIGNUM_W_DEFAULT = 18;
  localparam int unsigned STG_W            = 5;
  localparam int unsigned MC_DATA_W        = 512;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    LOAD_EXT,
    CALC,
    CALC_END,
`ifdef FFT_FILTER_EN
    FILT,
`endif
    UNLOAD,
    WAIT_DRAIN
  } fft_state_e;

endpackage

// File: rtl/fft_stage_counter.sv
// Butterfly position counter: cycle index wraps every NPOINT/2 and bumps the stage.
// Holds zero while disabled and self-clears after the final butterfly cycle.
module fft_stage_counter
  import fft_pkg::*;
#(
  parameter  int unsigned NPOINT = 1024,
  localparam int unsigned STAGES = $clog2(NPOINT),
  localparam int unsigned CYC_W  = $clog2(NPOINT / 2)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [STG_W-1:0] o_stage,
  output logic [CYC_W-1:0] o_cycle,
  output logic             o_last
);

  localparam logic [STG_W-1:0] LAST_STG = STG_W'(STAGES - 1);

  assign o_last = (o_stage == LAST_STG) && (&o_cycle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_stage <= '0;
      o_cycle <= '0;
    end else if (i_en && !o_last) begin
      o_cycle <= o_cycle + CYC_W'(1);
      if (&o_cycle) o_stage <= o_stage + STG_W'(1);
    end else begin
      o_stage <= '0;
      o_cycle <= '0;
    end
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// FFT sequencing controller: start -> load -> butterflies -> (filter) -> unload -> drain.
// Optional filter pass compiled in with FFT_FILTER_EN.
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter  int unsigned NPOINT   = 1024,
  parameter  int unsigned SIGNUM_W = SIGNUM_W_DEFAULT,
  localparam int unsigned STAGES   = $clog2(NPOINT),
  localparam int unsigned CYC_W    = $clog2(NPOINT / 2)
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                startF,
  input  logic                startI,
  input  logic [SIGNUM_W-1:0] sigNum,
  input  logic                filter,
  input  logic                inFifoReady,
  input  logic                loadExternalDone,
  input  logic                accelWrBlkDone,
  output logic                calculating,
  output logic                isInverse,
  output logic [SIGNUM_W-1:0] sigNumMC,
  output logic                loadExternal,
  output logic                loadInternal,
  output logic                loadOutBuffer,
  output logic                filterActive,
  output logic [STG_W-1:0]    stageCount,
  output logic [CYC_W-1:0]    cycleCount,
  output logic                doneCalculating,
  output logic                outFifoReady,
  output logic                done
);

  fft_state_e        r_state;
  logic [STAGES-1:0] r_cnt;
  logic [CYC_W-1:0]  w_cycle;
  logic              w_last;
  logic              w_calc_en;

  assign w_calc_en = (r_state == CALC);

  fft_stage_counter #(.NPOINT(NPOINT)) u_stage_counter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_calc_en),
    .o_stage (stageCount),
    .o_cycle (w_cycle),
    .o_last  (w_last)
  );

`ifdef FFT_FILTER_EN
  logic r_filter;
  // During the filter pass the frame counter doubles as the bin index.
  assign cycleCount = (r_state == FILT) ? r_cnt[CYC_W-1:0] : w_cycle;
`else
  logic w_unused_filter;
  assign w_unused_filter = filter;
  assign filterActive    = 1'b0;
  assign cycleCount      = w_cycle;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      calculating     <= 1'b0;
      isInverse       <= 1'b0;
      sigNumMC        <= '0;
      loadExternal    <= 1'b0;
      loadInternal    <= 1'b0;
      loadOutBuffer   <= 1'b0;
      doneCalculating <= 1'b0;
      outFifoReady    <= 1'b0;
      done            <= 1'b0;
`ifdef FFT_FILTER_EN
      r_filter        <= 1'b0;
      filterActive    <= 1'b0;
`endif
    end else begin
      doneCalculating <= 1'b0;
      done            <= 1'b0;
      case (r_state)
        IDLE: begin
          if (startF ^ startI) begin
            r_state     <= WAIT_IN;
            calculating <= 1'b1;
            isInverse   <= startI;
            sigNumMC    <= sigNum;
`ifdef FFT_FILTER_EN
            r_filter    <= filter & startF;
`endif
          end
        end
        WAIT_IN: begin
          if (inFifoReady) begin
            r_state      <= LOAD_EXT;
            loadExternal <= 1'b1;
          end
        end
        LOAD_EXT: begin
          if (loadExternalDone) begin
            r_state      <= CALC;
            loadExternal <= 1'b0;
            loadInternal <= 1'b1;
          end
        end
        CALC: begin
          if (w_last) begin
            r_state         <= CALC_END;
            loadInternal    <= 1'b0;
            doneCalculating <= 1'b1;
          end
        end
        CALC_END: begin
`ifdef FFT_FILTER_EN
          if (r_filter) begin
            r_state      <= FILT;
            filterActive <= 1'b1;
          end else begin
            r_state       <= UNLOAD;
            loadOutBuffer <= 1'b1;
          end
`else
          r_state       <= UNLOAD;
          loadOutBuffer <= 1'b1;
`endif
        end
`ifdef FFT_FILTER_EN
        FILT: begin
          r_cnt <= r_cnt + STAGES'(1);
          if (&r_cnt) begin
            r_state       <= UNLOAD;
            filterActive  <= 1'b0;
            loadOutBuffer <= 1'b1;
          end
        end
`endif
        UNLOAD: begin
          r_cnt <= r_cnt + STAGES'(1);
          if (&r_cnt) begin
            r_state       <= WAIT_DRAIN;
            loadOutBuffer <= 1'b0;
            outFifoReady  <= 1'b1;
          end
        end
        WAIT_DRAIN: begin
          if (accelWrBlkDone) begin
            r_state      <= IDLE;
            outFifoReady <= 1'b0;
            calculating  <= 1'b0;
            done         <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl: a 1024-point and a 16-point instance,
// each frame checked cycle by cycle against a phase-timeline model.
module tb_fft_seq_ctrl;

  localparam int unsigned NP0 = 1024;
  localparam int unsigned NP1 = 16;
`ifdef FFT_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        startF[2], startI[2], filter[2];
  logic        inFifoReady[2], loadExternalDone[2], accelWrBlkDone[2];
  logic [17:0] sigNum[2], sigNumMC[2];
  logic        calculating[2], isInverse[2], loadExternal[2], loadInternal[2];
  logic        loadOutBuffer[2], filterActive[2], doneCalculating[2];
  logic        outFifoReady[2], done[2];
  logic [4:0]  stageCount[2];
  logic [8:0]  cyc0;
  logic [2:0]  cyc1;

  int tests  = 0;
  int failed = 0;

  // Current frame: parameters and phase boundaries (cycle index t, t=0 is first cycle after start)
  int          m_n, m_w, m_l, m_d;
  bit          m_inv, m_filt;
  logic [17:0] m_sig;
  int          m_le_s, m_le_e, m_c_s, m_c_e, m_ce, m_f_s, m_u_s, m_u_e, m_wd_s, m_wd_e;

  always #5 clk = ~clk;

  fft_seq_ctrl #(.NPOINT(NP0), .SIGNUM_W(18)) u_dut0 (
    .clk(clk), .rst(rst), .startF(startF[0]), .startI(startI[0]), .sigNum(sigNum[0]),
    .filter(filter[0]), .inFifoReady(inFifoReady[0]), .loadExternalDone(loadExternalDone[0]),
    .accelWrBlkDone(accelWrBlkDone[0]), .calculating(calculating[0]), .isInverse(isInverse[0]),
    .sigNumMC(sigNumMC[0]), .loadExternal(loadExternal[0]), .loadInternal(loadInternal[0]),
    .loadOutBuffer(loadOutBuffer[0]), .filterActive(filterActive[0]), .stageCount(stageCount[0]),
    .cycleCount(cyc0), .doneCalculating(doneCalculating[0]), .outFifoReady(outFifoReady[0]),
    .done(done[0])
  );

  fft_seq_ctrl #(.NPOINT(NP1), .SIGNUM_W(18)) u_dut1 (
    .clk(clk), .rst(rst), .startF(startF[1]), .startI(startI[1]), .sigNum(sigNum[1]),
    .filter(filter[1]), .inFifoReady(inFifoReady[1]), .loadExternalDone(loadExternalDone[1]),
    .accelWrBlkDone(accelWrBlkDone[1]), .calculating(calculating[1]), .isInverse(isInverse[1]),
    .sigNumMC(sigNumMC[1]), .loadExternal(loadExternal[1]), .loadInternal(loadInternal[1]),
    .loadOutBuffer(loadOutBuffer[1]), .filterActive(filterActive[1]), .stageCount(stageCount[1]),
    .cycleCount(cyc1), .doneCalculating(doneCalculating[1]), .outFifoReady(outFifoReady[1]),
    .done(done[1])
  );

  // {calculating, isInverse, sigNumMC, loadExternal, loadInternal, loadOutBuffer,
  //  filterActive, stageCount, cycleCount, doneCalculating, outFifoReady, done}
  function automatic logic [40:0] act_vec(input int d);
    logic [8:0] cyc;
    cyc = (d == 0) ? cyc0 : {6'b0, cyc1};
    return {calculating[d], isInverse[d], sigNumMC[d], loadExternal[d], loadInternal[d],
            loadOutBuffer[d], filterActive[d], stageCount[d], cyc, doneCalculating[d],
            outFifoReady[d], done[d]};
  endfunction

  function automatic logic [40:0] exp_vec(input int t);
    int         half;
    logic       calc, lext, lint, lout, filt, donec, ofr, dn;
    logic [4:0] stg;
    logic [8:0] cyc;
    half  = m_n / 2;
    calc  = (t <= m_wd_e);
    lext  = (t >= m_le_s) && (t <= m_le_e);
    lint  = (t >= m_c_s) && (t <= m_c_e);
    donec = (t == m_ce);
    filt  = m_filt && (t >= m_f_s) && (t < m_f_s + m_n);
    lout  = (t >= m_u_s) && (t <= m_u_e);
    ofr   = (t >= m_wd_s) && (t <= m_wd_e);
    dn    = (t == m_wd_e + 1);
    stg   = '0;
    cyc   = '0;
    if (lint) begin
      stg = 5'((t - m_c_s) / half);
      cyc = 9'((t - m_c_s) % half);
    end
    if (filt) cyc = 9'((t - m_f_s) % half);
    return {calc, m_inv, m_sig, lext, lint, lout, filt, stg, cyc, donec, ofr, dn};
  endfunction

  task automatic drive_zero(input int d);
    startF[d] = 1'b0; startI[d] = 1'b0; filter[d] = 1'b0; sigNum[d] = '0;
    inFifoReady[d] = 1'b0; loadExternalDone[d] = 1'b0; accelWrBlkDone[d] = 1'b0;
  endtask

  // Runs one frame starting from an IDLE cycle at a negedge; ends at the negedge of the done cycle.
  // abort_off >= 0 drops rst that many cycles after CALC begins.
  task automatic run_frame(input string name, input int d, input bit inv, input logic [17:0] sig,
                           input bit freq, input int w, input int l, input int dd, input int abort_off);
    bit          quiet;
    int          abort_t;
    logic [40:0] av, ev;
    quiet  = 1'b0;
    m_n    = (d == 0) ? NP0 : NP1;
    m_inv  = inv; m_sig = sig; m_w = w; m_l = l; m_d = dd;
    m_filt = FILT_EN && freq && !inv;
    m_le_s = w + 1;
    m_le_e = m_le_s + l;
    m_c_s  = m_le_e + 1;
    m_c_e  = m_c_s + $clog2(m_n) * (m_n / 2) - 1;
    m_ce   = m_c_e + 1;
    m_f_s  = m_ce + 1;
    m_u_s  = m_ce + 1 + (m_filt ? m_n : 0);
    m_u_e  = m_u_s + m_n - 1;
    m_wd_s = m_u_e + 1;
    m_wd_e = m_wd_s + dd;
    abort_t = (abort_off >= 0) ? m_c_s + abort_off : -1;
    drive_zero(d);
    startF[d] = !inv; startI[d] = inv; sigNum[d] = sig; filter[d] = freq;
    for (int t = 0; t <= m_wd_e + 1; t++) begin
      @(negedge clk);
      av = act_vec(d);
      ev = exp_vec(t);
      if (!quiet) begin
        tests++;
        if (av !== ev) begin
          $display("FAIL %s t=%0d got=%h exp=%h", name, t, av, ev);
          failed++;
          quiet = 1'b1;
        end
      end
      if (t == abort_t) begin
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
          tests++;
          if (act_vec(k) !== '0) begin
            $display("FAIL %s_async_reset dut=%0d got=%h exp=0", name, k, act_vec(k));
            failed++;
          end
        end
        drive_zero(d);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (t > m_wd_e) begin
        drive_zero(d);
      end else begin
        startF[d]           = ($urandom_range(0, 15) == 0);
        startI[d]           = ($urandom_range(0, 15) == 0);
        sigNum[d]           = 18'($urandom);
        filter[d]           = ($urandom_range(0, 1) == 1);
        inFifoReady[d]      = (t == w) ? 1'b1 : (t > w) && ($urandom_range(0, 1) == 1);
        loadExternalDone[d] = (t == m_le_e) ? 1'b1 :
                              ((t < m_le_s) || (t > m_le_e)) && ($urandom_range(0, 3) == 0);
        accelWrBlkDone[d]   = (t == m_wd_e) ? 1'b1 : (t < m_wd_s) && ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (act_vec(k) !== '0) begin
        $display("FAIL reset_state dut=%0d got=%h exp=0", k, act_vec(k));
        failed++;
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_fwd_1024();
    run_frame("fwd1024", 0, 1'b0, 18'h00001, 1'b0, 0, 200, 3, -1);
  endtask

  task automatic test_inv_16();
    run_frame("inv16", 1, 1'b1, 18'($urandom), 1'b0, 2, 5, 4, -1);
  endtask

  task automatic test_filter();
    run_frame("filt_fwd16", 1, 1'b0, 18'($urandom), 1'b1, 1, 3, 2, -1);
    run_frame("filt_inv16", 1, 1'b1, 18'($urandom), 1'b1, 0, 2, 1, -1);
    run_frame("filt_fwd1024", 0, 1'b0, 18'($urandom), 1'b1, 1, 20, 2, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      run_frame("b2b16", 1, ($urandom_range(0, 1) == 1), 18'($urandom), 1'b0, 0, 0, 0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_frame("rand16", 1, ($urandom_range(0, 1) == 1), 18'($urandom),
                ($urandom_range(0, 1) == 1), $urandom_range(0, 3), $urandom_range(0, 20),
                $urandom_range(0, 6), -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_abort();
    run_frame("abort_calc1024", 0, 1'b0, 18'($urandom), 1'b0, 1, 10, 0, 5 * 512 + 100);
    run_frame("abort_unload16", 1, 1'b1, 18'($urandom), 1'b0, 0, 1, 0, 4 * 8 + 1 + 5);
  endtask

  task automatic test_both_starts();
    for (int k = 0; k < 2; k++) begin
      startF[k] = 1'b1; startI[k] = 1'b1; sigNum[k] = 18'h3ffff;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) drive_zero(k);
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (act_vec(k) !== '0) begin
          $display("FAIL both_starts dut=%0d cyc=%0d got=%h exp=0", k, c, act_vec(k));
          failed++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fresh_after_reset();
    run_frame("fresh16", 1, 1'b0, 18'($urandom), 1'b0, 1, 2, 1, -1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) drive_zero(k);
    test_reset();
    test_fwd_1024();
    test_inv_16();
    test_filter();
    test_back_to_back();
    test_random();
    test_abort();
    test_both_starts();
    test_fresh_after_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 Parameter NPOINT, default 1024, meaning FFT length (power of two, 16..4096).
REQ-002 Parameter SIGNUM_W, default 18, meaning signal-number width.
REQ-003 Derived constants: STAGES = log2(NPOINT); CYC_W = log2(NPOINT/2); STG_W = 5.
REQ-004 clk  input  1  one clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 startF / startI  input  1 each  start forward / inverse transform.
REQ-007 sigNum  input  SIGNUM_W  signal number sampled at start.
REQ-008 filter  input  1  request filter pass, sampled at start.
REQ-009 inFifoReady  input  1  input FIFO holds a full NPOINT frame.
REQ-010 loadExternalDone  input  1  external-to-working RAM copy finished.
REQ-011 accelWrBlkDone  input  1  host has drained the output FIFO.
REQ-012 calculating  output  1  transform in progress.
REQ-013 isInverse  output  1  latched mode, 1 = IFFT.
REQ-014 sigNumMC  output  SIGNUM_W  latched signal number.
REQ-015 loadExternal, loadInternal, loadOutBuffer, filterActive  output  1 each  phase strobes.
REQ-016 stageCount  output  STG_W; cycleCount  output  CYC_W  butterfly position.
REQ-017 doneCalculating  output  1  one-cycle pulse at end of butterflies.
REQ-018 outFifoReady  output  1; done  output  1  one-cycle completion pulse.

Function
REQ-019 States SHALL be IDLE, WAIT_IN, LOAD_EXT, CALC, CALC_END, FILT, UNLOAD, WAIT_DRAIN.
REQ-020 IDLE: exactly one of startF/startI high -> latch sigNum, isInverse, filter; go WAIT_IN; calculating high from next cycle.
REQ-021 startF and startI both high in IDLE SHALL be ignored; starts outside IDLE SHALL be ignored.
REQ-022 WAIT_IN: inFifoReady high -> LOAD_EXT; loadExternal high every LOAD_EXT cycle, including the cycle loadExternalDone is high.
REQ-023 loadExternalDone high in LOAD_EXT -> CALC next cycle, stageCount=0, cycleCount=0.
REQ-024 CALC: loadInternal high; cycleCount increments 0..NPOINT/2-1, wraps to 0 and increments stageCount; exactly STAGES*NPOINT/2 cycles.
REQ-025 After stage STAGES-1 cycle NPOINT/2-1 -> CALC_END: loadInternal low, doneCalculating high one cycle.
REQ-026 CALC_END -> FILT if filter latched and feature compiled in, else UNLOAD.
REQ-027 UNLOAD: loadOutBuffer high exactly NPOINT consecutive cycles, then WAIT_DRAIN.
REQ-028 WAIT_DRAIN: outFifoReady high; accelWrBlkDone high -> done pulse, calculating low, sigNumMC held, IDLE next cycle.
REQ-029 stageCount/cycleCount SHALL hold 0 outside CALC.
REQ-030 Inputs other than listed transitions SHALL have no effect in any state.

Reset
REQ-031 rst low at any time SHALL force IDLE asynchronously with every output 0, including mid-CALC or mid-UNLOAD.
REQ-032 First start after rst release SHALL behave as a fresh run.

Configuration
REQ-033 Macro FFT_FILTER_EN defined: FILT state present; filterActive high exactly NPOINT cycles, cycleCount reused as bin index (low CYC_W bits), then UNLOAD; filter honoured for startF only.
REQ-034 FFT_FILTER_EN undefined: filter input ignored, filterActive tied 0, FILT state absent.

Structure
REQ-035 Package fft_pkg SHALL hold the state enum, SIGNUM_W default, STG_W and MC_DATA_W=512.
REQ-036 Sub-module fft_stage_counter SHALL implement the stage/cycle counter with wrap and last-cycle flag.

Verification
REQ-037 NPOINT=1024, startF, sigNum=18'h00001 -> next cycle sigNumMC=1, calculating=1.
REQ-038 inFifoReady=1, loadExternalDone after 200 cycles -> loadExternal high 200+ cycles, then 10x512 loadInternal cycles with matching stage/cycle, then doneCalculating 1 cycle.
REQ-039 Continue -> loadOutBuffer high exactly 1024 cycles, then outFifoReady=1; accelWrBlkDone -> done pulse, IDLE.
REQ-040 NPOINT=16, startI -> isInverse=1, 4x8 CALC cycles, 16 UNLOAD cycles.
REQ-041 rst low at stage 5 cycle 100 -> all outputs 0 immediately; startF and startI together afterwards -> stays IDLE.
REQ-042 FFT_FILTER_EN defined, startF with filter=1 -> filterActive 1024 cycles between CALC_END and UNLOAD; startI with filter=1 -> no FILT.
